// File: rtl/vga_sync.sv
// 640x480@60 VGA raster timing: a /4 pixel enable, horizontal and vertical scan counters,
// and registered active-low syncs that stay cycle-aligned with the pixel coordinates.
module vga_sync #(
    parameter int unsigned HD  = 640,
    parameter int unsigned HFP = 16,
    parameter int unsigned HSW = 96,
    parameter int unsigned HBP = 48,
    parameter int unsigned VD  = 480,
    parameter int unsigned VFP = 10,
    parameter int unsigned VSW = 2,
    parameter int unsigned VBP = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_end
);

    localparam int unsigned HT = HD + HFP + HSW + HBP;
    localparam int unsigned VT = VD + VFP + VSW + VBP;

    localparam logic [9:0] H_MAX    = 10'(HT - 1);
    localparam logic [9:0] V_MAX    = 10'(VT - 1);
    localparam logic [9:0] H_VIS    = 10'(HD);
    localparam logic [9:0] V_VIS    = 10'(VD);
    localparam logic [9:0] HS_START = 10'(HD + HFP);
    localparam logic [9:0] HS_END   = 10'(HD + HFP + HSW - 1);
    localparam logic [9:0] VS_START = 10'(VD + VFP);
    localparam logic [9:0] VS_END   = 10'(VD + VFP + VSW - 1);

    logic [1:0] div;
    logic [9:0] h;
    logic [9:0] v;
    logic [9:0] next_h;
    logic [9:0] next_v;
    logic       h_end;
    logic       v_end;

    assign p_tick = (div == 2'd3);
    assign h_end  = (h == H_MAX);
    assign v_end  = (v == V_MAX);

    always_comb begin
        next_h = h;
        next_v = v;
        if (p_tick) begin
            next_h = h_end ? 10'd0 : h + 10'd1;
            if (h_end) begin
                next_v = v_end ? 10'd0 : v + 10'd1;
            end
        end
    end

    // Syncs are decoded from next_h/next_v so the registered pulse edges land
    // on the same clk edge as the matching coordinate change.
    always_ff @(posedge clk) begin
        if (reset) begin
            div   <= 2'd0;
            h     <= 10'd0;
            v     <= 10'd0;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else begin
            div   <= div + 2'd1;
            h     <= next_h;
            v     <= next_v;
            hsync <= !((next_h >= HS_START) && (next_h <= HS_END));
            vsync <= !((next_v >= VS_START) && (next_v <= VS_END));
        end
    end

    assign pixel_x   = h;
    assign pixel_y   = v;
    assign video_on  = (h < H_VIS) && (v < V_VIS);
    assign frame_end = p_tick && h_end && v_end;

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: a full-size instance for pixel/line timing and a shrunken-raster
// instance so whole frames fit in a short run; both are tracked by a cycle-count model.
module tb_vga_sync;

    localparam int HD_B = 16, HFP_B = 2, HSW_B = 3, HBP_B = 2;
    localparam int VD_B = 6, VFP_B = 2, VSW_B = 2, VBP_B = 3;
    localparam int HT_B = HD_B + HFP_B + HSW_B + HBP_B;
    localparam int VT_B = VD_B + VFP_B + VSW_B + VBP_B;
    localparam int FRAME_B = HT_B * VT_B * 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_a, reset_b;
    logic       p_tick_a, video_on_a, hsync_a, vsync_a, frame_end_a;
    logic [9:0] pixel_x_a, pixel_y_a;
    logic       p_tick_b, video_on_b, hsync_b, vsync_b, frame_end_b;
    logic [9:0] pixel_x_b, pixel_y_b;

    vga_sync dut_a (
        .clk      (clk),
        .reset    (reset_a),
        .p_tick   (p_tick_a),
        .pixel_x  (pixel_x_a),
        .pixel_y  (pixel_y_a),
        .video_on (video_on_a),
        .hsync    (hsync_a),
        .vsync    (vsync_a),
        .frame_end(frame_end_a)
    );

    vga_sync #(
        .HD(HD_B), .HFP(HFP_B), .HSW(HSW_B), .HBP(HBP_B),
        .VD(VD_B), .VFP(VFP_B), .VSW(VSW_B), .VBP(VBP_B)
    ) dut_b (
        .clk      (clk),
        .reset    (reset_b),
        .p_tick   (p_tick_b),
        .pixel_x  (pixel_x_b),
        .pixel_y  (pixel_y_b),
        .video_on (video_on_b),
        .hsync    (hsync_b),
        .vsync    (vsync_b),
        .frame_end(frame_end_b)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: everything follows from n = clk edges since the last reset edge.
    // Packed as {x, y, p_tick, video_on, hsync, vsync, frame_end}.
    function automatic logic [24:0] model(input int n, input int hd, input int hfp, input int hsw,
                                          input int hbp, input int vd, input int vfp, input int vsw,
                                          input int vbp);
        int ht = hd + hfp + hsw + hbp;
        int vt = vd + vfp + vsw + vbp;
        int pix = n / 4;
        int x = pix % ht;
        int y = (pix / ht) % vt;
        logic tick, hs, vs, von, fe;
        logic [9:0] xs, ys;
        tick = (n % 4) == 3;
        hs   = !(x >= hd + hfp && x < hd + hfp + hsw);
        vs   = !(y >= vd + vfp && y < vd + vfp + vsw);
        von  = (x < hd) && (y < vd);
        fe   = tick && (x == ht - 1) && (y == vt - 1);
        xs   = x[9:0];
        ys   = y[9:0];
        return {xs, ys, tick, von, hs, vs, fe};
    endfunction

    int   n_a = 0, n_b = 0;
    logic valid_a = 1'b0, valid_b = 1'b0;

    always @(posedge clk) begin
        if (reset_a) begin
            n_a     <= 0;
            valid_a <= 1'b1;
        end else begin
            n_a <= n_a + 1;
        end
        if (reset_b) begin
            n_b     <= 0;
            valid_b <= 1'b1;
        end else begin
            n_b <= n_b + 1;
        end
    end

    always @(negedge clk) begin
        if (valid_a)
            check("model_a",
                  32'({pixel_x_a, pixel_y_a, p_tick_a, video_on_a, hsync_a, vsync_a, frame_end_a}),
                  32'(model(n_a, 640, 16, 96, 48, 480, 10, 2, 33)));
        if (valid_b)
            check("model_b",
                  32'({pixel_x_b, pixel_y_b, p_tick_b, video_on_b, hsync_b, vsync_b, frame_end_b}),
                  32'(model(n_b, HD_B, HFP_B, HSW_B, HBP_B, VD_B, VFP_B, VSW_B, VBP_B)));
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_reset_a(input int cycles);
        @(negedge clk);
        reset_a = 1'b1;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        reset_a = 1'b0;
    endtask

    task automatic pulse_reset_b(input int cycles);
        @(negedge clk);
        reset_b = 1'b1;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        reset_b = 1'b0;
    endtask

    // ---------------- vectors for the full-size raster ----------------
    typedef struct {
        int         n;
        logic [9:0] x;
        logic [9:0] y;
        logic       tick;
        logic       hs;
        logic       vs;
        logic       von;
        logic       fe;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int cur;
        int ticks, cyc, fall1, fall2, low_cycles, x_at_fall;
        int fe_count, fe_first, fe_second, vis, vs_low, vs_ymin, vs_ymax, von_on_vd;
        logic prev;

        tbl = '{
            '{0,    10'd0,   10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0},
            '{3,    10'd0,   10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0},
            '{4,    10'd1,   10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0},
            '{2559, 10'd639, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0},
            '{2560, 10'd640, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0},
            '{2623, 10'd655, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0},
            '{2624, 10'd656, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0},
            '{3003, 10'd750, 10'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0},
            '{3004, 10'd751, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0},
            '{3008, 10'd752, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0},
            '{3199, 10'd799, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0},
            '{3200, 10'd0,   10'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0},
            '{5824, 10'd656, 10'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}
        };

        reset_a = 1'b1;
        reset_b = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_a = 1'b0;
        reset_b = 1'b0;

        // Table walk: one reset, advance to each listed edge count.
        cur = 0;
        for (int i = 0; i < 13; i++) begin
            if (tbl[i].n != cur) begin
                repeat (tbl[i].n - cur) @(posedge clk);
                #1;
                cur = tbl[i].n;
            end
            check($sformatf("vec%0d_x", i), 32'(pixel_x_a), 32'(tbl[i].x));
            check($sformatf("vec%0d_y", i), 32'(pixel_y_a), 32'(tbl[i].y));
            check($sformatf("vec%0d_tick", i), 32'(p_tick_a), 32'(tbl[i].tick));
            check($sformatf("vec%0d_hsync", i), 32'(hsync_a), 32'(tbl[i].hs));
            check($sformatf("vec%0d_vsync", i), 32'(vsync_a), 32'(tbl[i].vs));
            check($sformatf("vec%0d_video_on", i), 32'(video_on_a), 32'(tbl[i].von));
            check($sformatf("vec%0d_frame_end", i), 32'(frame_end_a), 32'(tbl[i].fe));
        end

        // Pixel pacing over 40 clk after a fresh reset.
        pulse_reset_a(2);
        ticks = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            check("pace_tick", 32'(p_tick_a), ((i % 4) == 2) ? 32'd1 : 32'd0);
            if (p_tick_a) ticks++;
        end
        check("pace_tick_count", 32'(ticks), 32'd10);
        check("pace_x", 32'(pixel_x_a), 32'd10);

        // Line length and hsync width, measured between two hsync falls.
        cyc = 0; fall1 = -1; fall2 = -1; low_cycles = 0; x_at_fall = -1;
        prev = hsync_a;
        while (cyc < 8000 && fall2 < 0) begin
            @(posedge clk);
            #1;
            cyc++;
            if (prev && !hsync_a) begin
                if (fall1 < 0) begin
                    fall1 = cyc;
                    x_at_fall = int'(pixel_x_a);
                end else begin
                    fall2 = cyc;
                end
            end
            if (fall1 >= 0 && fall2 < 0 && !hsync_a) low_cycles++;
            prev = hsync_a;
        end
        check("hsync_fall_seen", 32'(fall2 >= 0), 32'd1);
        check("line_len", 32'(fall2 - fall1), 32'd3200);
        check("hsync_low_clks", 32'(low_cycles), 32'd384);
        check("hsync_fall_x", 32'(x_at_fall), 32'd656);

        // Mid-line reset while hsync is low.
        pulse_reset_a(1);
        repeat (2800) @(posedge clk);
        #1;
        check("mid_pre_x", 32'(pixel_x_a), 32'd700);
        check("mid_pre_hsync", 32'(hsync_a), 32'd0);
        @(negedge clk);
        reset_a = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_x", 32'(pixel_x_a), 32'd0);
        check("mid_rst_y", 32'(pixel_y_a), 32'd0);
        check("mid_rst_hsync", 32'(hsync_a), 32'd1);
        check("mid_rst_vsync", 32'(vsync_a), 32'd1);
        check("mid_rst_video_on", 32'(video_on_a), 32'd1);
        check("mid_rst_tick", 32'(p_tick_a), 32'd0);
        check("mid_rst_frame_end", 32'(frame_end_a), 32'd0);
        @(negedge clk);
        reset_a = 1'b0;

        // Whole frames on the small raster.
        pulse_reset_b(2);
        fe_count = 0; fe_first = -1; fe_second = -1; vis = 0; vs_low = 0;
        vs_ymin = 1023; vs_ymax = -1; von_on_vd = 0;
        for (int c = 1; c <= 2 * FRAME_B + 8; c++) begin
            @(posedge clk);
            #1;
            if (frame_end_b) begin
                fe_count++;
                if (fe_first < 0) fe_first = c;
                else if (fe_second < 0) fe_second = c;
            end
            if (c <= FRAME_B) begin
                if (p_tick_b && video_on_b) vis++;
                if (p_tick_b && !vsync_b) begin
                    vs_low++;
                    if (int'(pixel_y_b) < vs_ymin) vs_ymin = int'(pixel_y_b);
                    if (int'(pixel_y_b) > vs_ymax) vs_ymax = int'(pixel_y_b);
                end
                if (video_on_b && pixel_y_b == 10'(VD_B)) von_on_vd++;
            end
        end
        check("frame_end_count", 32'(fe_count), 32'd2);
        check("frame_end_first", 32'(fe_first), 32'(FRAME_B - 1));
        check("frame_period", 32'(fe_second - fe_first), 32'(FRAME_B));
        check("visible_pixels", 32'(vis), 32'(HD_B * VD_B));
        check("vsync_low_pixels", 32'(vs_low), 32'(VSW_B * HT_B));
        check("vsync_low_ymin", 32'(vs_ymin), 32'(VD_B + VFP_B));
        check("vsync_low_ymax", 32'(vs_ymax), 32'(VD_B + VFP_B + VSW_B - 1));
        check("video_on_line_vd", 32'(von_on_vd), 32'd0);

        // Mid-frame reset inside hsync low on the small raster (x=19, y=4).
        pulse_reset_b(1);
        repeat (4 * (4 * HT_B + 19)) @(posedge clk);
        #1;
        check("b_mid_pre_x", 32'(pixel_x_b), 32'd19);
        check("b_mid_pre_y", 32'(pixel_y_b), 32'd4);
        check("b_mid_pre_hsync", 32'(hsync_b), 32'd0);
        @(negedge clk);
        reset_b = 1'b1;
        @(posedge clk);
        #1;
        check("b_mid_rst_xy", 32'({pixel_x_b, pixel_y_b}), 32'd0);
        check("b_mid_rst_flags", 32'({p_tick_b, video_on_b, hsync_b, vsync_b, frame_end_b}),
              32'b01110);
        @(negedge clk);
        reset_b = 1'b0;

        // Random runs with sporadic resets; the per-cycle model does the checking.
        for (int ep = 0; ep < 20; ep++) begin
            int len;
            len = $urandom_range(50, 1500);
            for (int c = 0; c < len; c++) begin
                @(negedge clk);
                reset_a = ($urandom_range(0, 299) == 0);
                reset_b = ($urandom_range(0, 299) == 0);
            end
        end
        @(negedge clk);
        reset_a = 1'b0;
        reset_b = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
